// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern generator family: mode and direction
// encodings plus a ceil-log2 helper used for elaboration-time parameter checks.
package pattern_pkg;

  localparam logic [1:0] MODE_FIXED  = 2'b00;
  localparam logic [1:0] MODE_TRI    = 2'b01;
  localparam logic [1:0] MODE_MIRROR = 2'b10;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int unsigned v);
    int r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < longint'(v)) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/pattern_repeat_gen.sv
// Run-length pattern generator: emits START_VAL..MAX_VAL with per-mode repeat
// counts (FIXED, TRI, MIRROR), one element per enabled edge, with a period-end marker.
module pattern_repeat_gen
  import pattern_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int START_VAL = 1,
  parameter int MAX_VAL   = 9,
  parameter int REP_FIXED = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             last
);

  if (START_VAL + 2 > MAX_VAL) begin : g_bad_span
    $error("pattern_repeat_gen: START_VAL + 2 must not exceed MAX_VAL");
  end
  if (clog2(MAX_VAL + 1) > WIDTH) begin : g_bad_max
    $error("pattern_repeat_gen: MAX_VAL does not fit in WIDTH bits");
  end
  if (REP_FIXED < 1 || clog2(REP_FIXED + 1) > WIDTH) begin : g_bad_rep
    $error("pattern_repeat_gen: REP_FIXED must be in 1 .. 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] START_W = WIDTH'(START_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] REP_W   = WIDTH'(REP_FIXED);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] out_q;
  logic             valid_q, last_q;

  logic             is_tri, is_mirror;
  logic [WIDTH-1:0] target;
  logic             final_rep, final_val, period_end;

  // Mode 11 decodes as neither TRI nor MIRROR, so it behaves as FIXED.
  assign is_tri    = (mode_q == MODE_TRI);
  assign is_mirror = (mode_q == MODE_MIRROR);
  assign target    = is_tri ? (val_q - START_W + ONE_W) : REP_W;
  assign final_rep = ((cnt_q + ONE_W) == target);
  // MIRROR ends on the way down at START_VAL+1; the other modes end at the peak.
  assign final_val = is_mirror ? ((dir_q == DIR_DOWN) && (val_q == START_W + ONE_W))
                               : (val_q == MAX_W);
  assign period_end = final_rep && final_val;

  always_comb begin
    val_d  = val_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    if (en) begin
      if (!final_rep) begin
        cnt_d = cnt_q + ONE_W;
      end else begin
        cnt_d = '0;
        if (period_end) begin
          val_d  = START_W;
          dir_d  = DIR_UP;
          mode_d = mode;
        end else if (is_mirror && (dir_q == DIR_UP) && (val_q == MAX_W)) begin
          // Turn at the peak without emitting it a second time.
          dir_d = DIR_DOWN;
          val_d = MAX_W - ONE_W;
        end else if (dir_q == DIR_DOWN) begin
          val_d = val_q - ONE_W;
        end else begin
          val_d = val_q + ONE_W;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q   <= START_W;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      mode_q  <= mode;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      valid_q <= en;
      last_q  <= en && period_end;
      if (en) begin
        out_q <= val_q;
      end
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign last  = last_q;

endmodule

// File: tb/tb_pattern_repeat_gen.sv
// Directed bench for pattern_repeat_gen: the driver pushes expected {out,last}
// per enabled edge into a queue, and a negedge monitor pops and compares.
module tb_pattern_repeat_gen;
  import pattern_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [1:0]       mode = MODE_FIXED;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic             last;

  pattern_repeat_gen #(
    .WIDTH(WIDTH), .START_VAL(1), .MAX_VAL(9), .REP_FIXED(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .out(out), .valid(valid), .last(last)
  );

  always #5 clk = ~clk;

  // Scoreboard: each entry is {value, last}.
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] per_q[$];
  int             per_idx = 0;
  int             n_cmp = 0;
  int             n_err = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Hand-written period contents for START_VAL=1, MAX_VAL=9, REP_FIXED=2.
  task automatic load_period(input logic [1:0] m);
    per_q.delete();
    if (m == MODE_TRI) begin
      for (int v = 1; v <= 9; v++)
        for (int r = 0; r < v; r++) per_q.push_back({4'(v), 1'b0});
    end else if (m == MODE_MIRROR) begin
      for (int v = 1; v <= 9; v++) begin
        per_q.push_back({4'(v), 1'b0});
        per_q.push_back({4'(v), 1'b0});
      end
      for (int v = 8; v >= 2; v--) begin
        per_q.push_back({4'(v), 1'b0});
        per_q.push_back({4'(v), 1'b0});
      end
    end else begin
      for (int v = 1; v <= 9; v++) begin
        per_q.push_back({4'(v), 1'b0});
        per_q.push_back({4'(v), 1'b0});
      end
    end
    per_q[per_q.size()-1][0] = 1'b1;
    per_idx = 0;
  endtask

  task automatic cycle(input logic en_v, input logic [1:0] mode_v);
    logic [WIDTH:0] e;
    en   = en_v;
    mode = mode_v;
    if (en_v) begin
      e = per_q[per_idx];
      exp_q.push_back(e);
      per_idx++;
      // The mode present on the edge that emits last governs the next period.
      if (e[0]) load_period(mode_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] mode_v, input logic en_v, input int cycles);
    rst  = 1'b1;
    en   = en_v;
    mode = mode_v;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b0;
    load_period(mode_v);
  endtask

  task automatic run(input int n, input logic [1:0] mode_v);
    for (int i = 0; i < n; i++) cycle(1'b1, mode_v);
  endtask

  // Monitor: snapshot the inputs the DUT saw at each edge, compare at negedge.
  logic           rst_s = 1'b1;
  logic           en_s  = 1'b0;
  bit             edge_seen = 1'b0;
  logic [WIDTH-1:0] hold_v = '0;

  always @(posedge clk) begin
    rst_s     = rst;
    en_s      = en;
    edge_seen = 1'b1;
  end

  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (edge_seen) begin
      if (rst_s) begin
        check(out == '0 && !valid && !last, "reset_state", {out, valid, last}, 0);
        hold_v = '0;
      end else begin
        check(valid == en_s, "valid_follows_en", valid, en_s);
        if (valid) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_output", out, 0);
          end else begin
            e = exp_q.pop_front();
            check({out, last} == e, "element{out,last}", {out, last}, e);
          end
          hold_v = out;
        end else begin
          check(out == hold_v && !last, "stall_hold{out,last}", {out, last}, {hold_v, 1'b0});
        end
      end
    end
  end

  initial begin
    load_period(MODE_FIXED);

    // FIXED: a full period of 18 plus wrap to 1,1.
    do_reset(MODE_FIXED, 1'b0, 2);
    run(20, MODE_FIXED);

    // Stall pattern: stream 1,1,2,2 with out holding in between.
    do_reset(MODE_FIXED, 1'b0, 1);
    cycle(1'b1, MODE_FIXED); cycle(1'b1, MODE_FIXED);
    cycle(1'b0, MODE_FIXED); cycle(1'b0, MODE_FIXED);
    cycle(1'b1, MODE_FIXED); cycle(1'b0, MODE_FIXED);
    cycle(1'b1, MODE_FIXED); cycle(1'b0, MODE_FIXED);

    // Mode change mid-period only takes effect after the period's last element.
    do_reset(MODE_FIXED, 1'b0, 1);
    run(4, MODE_FIXED);
    run(14 + 10, MODE_TRI);

    // TRI: 45-element period plus wrap.
    do_reset(MODE_TRI, 1'b0, 1);
    run(48, MODE_TRI);

    // MIRROR: 32-element period plus wrap.
    do_reset(MODE_MIRROR, 1'b0, 1);
    run(34, MODE_MIRROR);

    // Mode 11 runs as FIXED.
    do_reset(2'b11, 1'b0, 1);
    run(20, 2'b11);

    // Reset mid-TRI with en high: reset wins, then restart at 1,2,2.
    do_reset(MODE_TRI, 1'b0, 1);
    run(19, MODE_TRI);
    do_reset(MODE_TRI, 1'b1, 1);
    run(3, MODE_TRI);
    cycle(1'b0, MODE_TRI);

    @(posedge clk); #1;
    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pattern_repeat_gen.md
# pattern_repeat_gen

Parametrised run-length pattern generator, the successor to the fixed "112233…" and "122333…" counters. It emits a value sequence from `START_VAL` to `MAX_VAL`, repeating each value according to a run-time-selectable mode, with stall control, a valid strobe and an end-of-period marker. It sits beside the other pattern generators as a stimulus and sequence source feeding display and checker logic.

## Interface
- `WIDTH`, 4: width of `out` and of the internal value and repeat counters.
- `START_VAL`, 1: first value of every period.
- `MAX_VAL`, 9: peak value. Required: `START_VAL + 2 <= MAX_VAL < 2**WIDTH`.
- `REP_FIXED`, 2: repeat count used in modes FIXED and MIRROR. Required: `1 <= REP_FIXED < 2**WIDTH`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `en`, in, 1: advance request; one element is emitted per edge where `en=1`.
- `mode`, in, 2: pattern select. 00 FIXED, 01 TRI, 10 MIRROR, 11 treated as FIXED.
- `out`, out, WIDTH: emitted element.
- `valid`, out, 1: `out` holds a new element this cycle.
- `last`, out, 1: the element on `out` is the final element of a period.

## Operation
- Internal state:
  - `val`: next value to emit.
  - `cnt`: repeats of `val` already emitted.
  - `dir`: UP or DOWN.
  - `mode_q`: latched mode.
- The sequence per mode is:
  - FIXED: each value `START_VAL..MAX_VAL` is emitted `REP_FIXED` times, then the period wraps to `START_VAL`.
  - TRI: value v is emitted `v-START_VAL+1` times (1, 22, 333, … for the default `START_VAL`), then the period wraps.
  - MIRROR: values rise `START_VAL..MAX_VAL` (dir UP), then fall `MAX_VAL-1..START_VAL+1` (dir DOWN), each emitted `REP_FIXED` times. The period then wraps to `START_VAL` with dir UP. The peak is not repeated twice.
- On an edge with `en=1`:
  - `out<=val`, `valid<=1`.
  - `last<=1` iff this is the final repeat of the final value of the period.
  - `val`, `cnt` and `dir` advance.
- On an edge with `en=0`: `valid<=0`, `last<=0`. `out`, `val`, `cnt` and `dir` hold, so no element is skipped or duplicated across stalls.
- `mode_q` is loaded from `mode` at reset and on the edge that emits a `last=1` element. At that edge the new mode governs the next period. Mode changes at any other time are ignored until the period boundary.
- Repeat target:
  - FIXED and MIRROR compare `cnt+1` against `REP_FIXED`.
  - TRI compares `cnt+1` against `val-START_VAL+1`.
  - All compares are at WIDTH bits, unsigned, and no intermediate may overflow given the parameter constraints.

## Timing
- Reset values: `out=0`, `valid=0`, `last=0`; internally `val=START_VAL`, `cnt=0`, `dir=UP`, `mode_q=mode`.
- Latency is 1 cycle: with `en` high at edge N, the element is on `out` with `valid=1` after edge N.
- With continuous `en`, throughput is one element per cycle with no bubbles at value changes or period wrap.
- Reset mid-operation has priority over `en`. After the reset edge, outputs return to reset values and the next `en` emits `START_VAL` under the mode sampled at reset.
- `last` is asserted for exactly the single cycle of its element. With `en=1` on the following edge, the next `out` is `START_VAL`.

## Structure
- Shared package `pattern_pkg`:
  - the 2-bit mode encoding constants (FIXED, TRI, MIRROR);
  - the `dir` encoding;
  - a `clog2` helper used for the parameter checks.
- Single flat module with one next-state block and one output register block. No sub-module is needed; the repeat-target compare is a few lines and stays inline.
- Include elaboration-time parameter assertions for the constraints listed under Interface.

## Test plan
- Default parameters, mode FIXED, `en` held 1 → 1,1,2,2,…,9,9,1,1 with no gaps; `last=1` only on element 18.
- Mode TRI, `en` held 1 → 1,2,2,3,3,3,…,nine 9s; period is 45 elements, `last` on the 45th, then 1.
- Mode MIRROR, `en` held 1 → 1,1,…,9,9,8,8,…,2,2 then 1,1; period is 32 elements, `last` on the second 2.
- FIXED with `en` pattern 1,1,0,0,1,0,1 → `valid` follows `en` delayed by 1 cycle; emitted stream is 1,1,2,2 with `out` holding during stalls.
- `mode` switched FIXED→TRI at element 5 → FIXED continues through element 18 (`last`); element 19 starts the TRI sequence at 1,2,2.
- TRI running, `rst` pulsed at element 20 → cycle after the reset edge shows `out=0`, `valid=0`, `last=0`. With `mode=01` held and `en=1`, the output restarts at 1,2,2.
